// File: rtl/pos_pkt_to_remote_axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : pos_pkt_to_remote_axis_packer
// Description : Buffers destination-tagged position records and packs them
//               into AXI-Stream beats for the inter-FPGA TX link.
// Revision    : 1.0 - initial release
// ============================================================================
module pos_pkt_to_remote_axis_packer #(
    parameter int REC_WIDTH     = 128,
    parameter int RECS_PER_BEAT = 4,
    parameter int NODE_ID_WIDTH = 3,
    parameter int FIFO_DEPTH    = 16,
    parameter int AFULL_THRESH  = 12
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [REC_WIDTH-1:0]                   i_pos_rec,
    input  logic [NODE_ID_WIDTH-1:0]               i_pos_rec_dest,
    input  logic                                   i_pos_rec_valid,
    input  logic                                   i_last_pos_sent,
    output logic                                   o_almost_full,
    output logic                                   o_overflow,
    output logic [REC_WIDTH*RECS_PER_BEAT-1:0]     o_tdata,
    output logic [REC_WIDTH*RECS_PER_BEAT/8-1:0]   o_tkeep,
    output logic [NODE_ID_WIDTH-1:0]               o_tdest,
    output logic                                   o_tlast,
    output logic                                   o_tvalid,
    input  logic                                   i_tready,
    output logic                                   o_idle,
    output logic [31:0]                            o_beats_sent,
    output logic [31:0]                            o_recs_sent
);

    localparam int c_data_w    = REC_WIDTH * RECS_PER_BEAT;
    localparam int c_keep_w    = c_data_w / 8;
    localparam int c_lane_keep = REC_WIDTH / 8;
    localparam int c_entry_w   = REC_WIDTH + NODE_ID_WIDTH + 2;
    localparam int c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int c_lane_w    = $clog2(RECS_PER_BEAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    // ---------------- input FIFO ----------------
    logic [c_entry_w-1:0]     r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]       r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]         r_count;
    logic                     r_overflow;
    logic                     w_wr_req, w_wr_en, w_full, w_empty, w_pop;
    logic [c_entry_w-1:0]     w_entry, w_head;

    assign w_wr_req = i_pos_rec_valid || i_last_pos_sent;
    assign w_full   = (r_count == (c_ptr_w+1)'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_wr_en  = w_wr_req && !w_full;
    // A bare end-of-burst marker carries zero dest and payload.
    assign w_entry  = {i_pos_rec_valid, i_last_pos_sent,
                       i_pos_rec_valid ? i_pos_rec_dest : NODE_ID_WIDTH'(0),
                       i_pos_rec_valid ? i_pos_rec : REC_WIDTH'(0)};
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_wr_req && w_full) r_overflow <= 1'b1;
        end
    end

    logic                     w_h_has_rec, w_h_eob;
    logic [NODE_ID_WIDTH-1:0] w_h_dest;
    logic [REC_WIDTH-1:0]     w_h_rec;
    assign w_h_has_rec = w_head[c_entry_w-1];
    assign w_h_eob     = w_head[c_entry_w-2];
    assign w_h_dest    = w_head[REC_WIDTH +: NODE_ID_WIDTH];
    assign w_h_rec     = w_head[REC_WIDTH-1:0];

    // ---------------- accumulator FSM ----------------
    logic [1:0]               r_state, w_state_nxt;
    logic [c_data_w-1:0]      r_acc_data, w_acc_data_nxt, w_app_data;
    logic [c_lane_w-1:0]      r_lanes, w_lanes_nxt, w_lanes_inc;
    logic [NODE_ID_WIDTH-1:0] r_acc_dest, w_dest_nxt;
    logic                     r_pend_last, w_pend_last_nxt;
    logic                     w_out_free, w_emit, w_emit_last;
    logic [c_data_w-1:0]      w_emit_data;
    logic [c_lane_w-1:0]      w_emit_lanes;
    logic [NODE_ID_WIDTH-1:0] w_emit_dest;
    logic [c_keep_w-1:0]      w_emit_keep;
    logic                     r_tvalid;

    assign w_out_free  = !r_tvalid || i_tready;
    assign w_lanes_inc = r_lanes + c_lane_w'(1);

    always_comb begin
        w_app_data = r_acc_data;
        for (int l = 0; l < RECS_PER_BEAT; l++) begin
            if (r_lanes == c_lane_w'(l)) w_app_data[l*REC_WIDTH +: REC_WIDTH] = w_h_rec;
        end
    end

    always_comb begin
        w_pop           = 1'b0;
        w_emit          = 1'b0;
        w_emit_last     = 1'b0;
        w_emit_data     = r_acc_data;
        w_emit_lanes    = r_lanes;
        w_emit_dest     = r_acc_dest;
        w_state_nxt     = r_state;
        w_acc_data_nxt  = r_acc_data;
        w_lanes_nxt     = r_lanes;
        w_dest_nxt      = r_acc_dest;
        w_pend_last_nxt = r_pend_last;
        if (r_state == S_STALL) begin
            if (w_out_free) begin
                w_emit      = 1'b1;
                w_emit_last = r_pend_last;
            end
        end else if (!w_empty) begin
            if (w_h_has_rec && (r_lanes == '0 || w_h_dest == r_acc_dest)) begin
                w_pop          = 1'b1;
                w_acc_data_nxt = w_app_data;
                w_lanes_nxt    = w_lanes_inc;
                w_dest_nxt     = w_h_dest;
                w_state_nxt    = S_FILL;
                if (w_lanes_inc == c_lane_w'(RECS_PER_BEAT) || w_h_eob) begin
                    w_pend_last_nxt = w_h_eob;
                    w_state_nxt     = S_STALL;
                    if (w_out_free) begin
                        w_emit       = 1'b1;
                        w_emit_last  = w_h_eob;
                        w_emit_data  = w_app_data;
                        w_emit_lanes = w_lanes_inc;
                        w_emit_dest  = w_h_dest;
                    end
                end
            end else if (w_h_has_rec) begin
                // Destination change: close the partial beat, keep the head for next cycle.
                w_pend_last_nxt = 1'b0;
                w_state_nxt     = S_STALL;
                w_emit          = w_out_free;
            end else begin
                w_pop           = 1'b1;
                w_pend_last_nxt = 1'b1;
                w_state_nxt     = S_STALL;
                w_emit          = w_out_free;
                w_emit_last     = 1'b1;
            end
        end
        if (w_emit) begin
            w_acc_data_nxt  = '0;
            w_lanes_nxt     = '0;
            w_dest_nxt      = '0;
            w_pend_last_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
        end
    end

    always_comb begin
        w_emit_keep = '0;
        for (int l = 0; l < RECS_PER_BEAT; l++) begin
            if (c_lane_w'(l) < w_emit_lanes) w_emit_keep[l*c_lane_keep +: c_lane_keep] = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc_data  <= '0;
            r_lanes     <= '0;
            r_acc_dest  <= '0;
            r_pend_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc_data  <= w_acc_data_nxt;
            r_lanes     <= w_lanes_nxt;
            r_acc_dest  <= w_dest_nxt;
            r_pend_last <= w_pend_last_nxt;
        end
    end

    // ---------------- output register and counters ----------------
    logic [c_data_w-1:0]      r_tdata;
    logic [c_keep_w-1:0]      r_tkeep;
    logic [NODE_ID_WIDTH-1:0] r_tdest;
    logic                     r_tlast;
    logic [31:0]              r_beats_sent, r_recs_sent, w_beat_recs;

    always_comb begin
        w_beat_recs = '0;
        for (int l = 0; l < RECS_PER_BEAT; l++) begin
            if (r_tkeep[l*c_lane_keep]) w_beat_recs = w_beat_recs + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tdest      <= '0;
            r_tlast      <= 1'b0;
            r_beats_sent <= '0;
            r_recs_sent  <= '0;
        end else begin
            if (w_emit) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_emit_data;
                r_tkeep  <= w_emit_keep;
                r_tdest  <= w_emit_dest;
                r_tlast  <= w_emit_last;
            end else if (i_tready) begin
                r_tvalid <= 1'b0;
            end
            if (r_tvalid && i_tready) begin
                r_beats_sent <= r_beats_sent + 32'd1;
                r_recs_sent  <= r_recs_sent + w_beat_recs;
            end
        end
    end

    assign o_almost_full = (r_count >= (c_ptr_w+1)'(AFULL_THRESH));
    assign o_overflow    = r_overflow;
    assign o_tdata       = r_tdata;
    assign o_tkeep       = r_tkeep;
    assign o_tdest       = r_tdest;
    assign o_tlast       = r_tlast;
    assign o_tvalid      = r_tvalid;
    assign o_idle        = w_empty && (r_lanes == '0) && (r_state != S_STALL) && !r_tvalid;
    assign o_beats_sent  = r_beats_sent;
    assign o_recs_sent   = r_recs_sent;

endmodule
`default_nettype wire

// File: tb/tb_pos_pkt_to_remote_axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pos_pkt_to_remote_axis_packer
// Description : Scoreboard bench; a record-level packing model predicts beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pos_pkt_to_remote_axis_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] pos_rec;
    logic [2:0]   pos_rec_dest;
    logic         pos_rec_valid;
    logic         last_pos_sent;
    logic         almost_full, overflow, tlast, tvalid, tready, idle;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic [2:0]   tdest;
    logic [31:0]  beats_sent, recs_sent;

    pos_pkt_to_remote_axis_packer dut (
        .clk(clk), .rst(rst),
        .i_pos_rec(pos_rec), .i_pos_rec_dest(pos_rec_dest),
        .i_pos_rec_valid(pos_rec_valid), .i_last_pos_sent(last_pos_sent),
        .o_almost_full(almost_full), .o_overflow(overflow),
        .o_tdata(tdata), .o_tkeep(tkeep), .o_tdest(tdest), .o_tlast(tlast),
        .o_tvalid(tvalid), .i_tready(tready), .o_idle(idle),
        .o_beats_sent(beats_sent), .o_recs_sent(recs_sent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Expected beats packed as {data, keep, dest, last}
    logic [579:0] exp_q [$];
    logic [127:0] m_recs [$];
    logic [2:0]   m_dest;
    logic [31:0]  exp_beats, exp_recs;

    task automatic model_flush(input logic last);
        logic [511:0] d = '0;
        logic [63:0]  k = '0;
        for (int i = 0; i < m_recs.size(); i++) begin
            d[i*128 +: 128] = m_recs[i];
            k[i*16 +: 16]   = '1;
        end
        exp_q.push_back({d, k, (m_recs.size() > 0) ? m_dest : 3'd0, last});
        exp_beats = exp_beats + 32'd1;
        exp_recs  = exp_recs + 32'(m_recs.size());
        m_recs.delete();
    endtask

    task automatic model_entry(input logic v, input logic l, input logic [2:0] d, input logic [127:0] r);
        if (v) begin
            if (m_recs.size() > 0 && d != m_dest) model_flush(1'b0);
            m_recs.push_back(r);
            m_dest = d;
            if (m_recs.size() == 4 || l) model_flush(l);
        end else if (l) begin
            model_flush(1'b1);
        end
    endtask

    // Drive one cycle of input; the DUT samples it on the next rising edge.
    task automatic drive(input logic v, input logic l, input logic [2:0] d,
                         input logic [127:0] r, input logic accept);
        pos_rec_valid = v;
        last_pos_sent = l;
        pos_rec_dest  = d;
        pos_rec       = r;
        if (accept) model_entry(v, l, d, r);
        @(posedge clk); #1;
        pos_rec_valid = 1'b0;
        last_pos_sent = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        logic done = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && idle) done = 1'b1;
        end
        check({name, "_drain"}, 640'(done), 640'(1));
        @(posedge clk); #1;
    endtask

    task automatic check_counters(input string name);
        check({name, "_beats"}, 640'(beats_sent), 640'(exp_beats));
        check({name, "_recs"}, 640'(recs_sent), 640'(exp_recs));
    endtask

    // Monitor: compares each accepted beat and checks stability under backpressure.
    logic         hold_v = 1'b0;
    logic [579:0] hold_beat;
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("stall_stable", {tvalid, tdata, tkeep, tdest, tlast}, {1'b1, hold_beat});
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got=%0h want=none", {tdata, tkeep, tdest, tlast});
                end else begin
                    check("beat", {tdata, tkeep, tdest, tlast}, exp_q.pop_front());
                end
            end
            hold_v    = tvalid && !tready;
            hold_beat = {tdata, tkeep, tdest, tlast};
        end
    end

    initial begin
        rst = 1'b1; tready = 1'b1;
        pos_rec = '0; pos_rec_dest = '0; pos_rec_valid = 1'b0; last_pos_sent = 1'b0;
        exp_beats = '0; exp_recs = '0; m_dest = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", 640'(tvalid), 640'(0));
        check("rst_idle", 640'(idle), 640'(1));
        check("rst_flags", 640'({almost_full, overflow}), 640'(0));
        check("rst_out", 640'({tdata, tkeep, tdest, tlast}), 640'(0));
        check_counters("rst");
        @(posedge clk); #1;

        // 1: four records to node 2, latency, then a lone end-of-burst marker
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 3'd2, 128'(i), 1'b1);
        @(negedge clk);
        check("lat_edge1", 640'(tvalid), 640'(0));
        @(negedge clk);
        check("lat_edge2", 640'(tvalid), 640'(1));
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd0, '0, 1'b1);
        drain("t1");
        check("t1_beats_abs", 640'(beats_sent), 640'(2));
        check("t1_recs_abs", 640'(recs_sent), 640'(4));

        // 2: six records to node 1, last one closes the burst
        for (int i = 0; i < 6; i++) drive(1'b1, i == 5, 3'd1, 128'(16'h100 + i), 1'b1);
        drain("t2");

        // 3: destination change inside a burst
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, (i < 2) ? 3'd1 : 3'd3, 128'(16'h200 + i), 1'b1);
        drive(1'b0, 1'b1, 3'd0, '0, 1'b1);
        drain("t3");
        check_counters("t3");

        // 4: sink stalled, source ignores almost_full; FIFO + accumulator + output hold 24
        tready = 1'b0;
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, 3'd4, 128'(16'h300 + i), i < 24);
        @(negedge clk);
        check("t4_afull", 640'(almost_full), 640'(1));
        check("t4_overflow", 640'(overflow), 640'(1));
        @(posedge clk); #1;
        drain("t4");
        check("t4_overflow_sticky", 640'(overflow), 640'(1));
        check_counters("t4");

        // 5: reset while a beat is presented
        tready = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 3'd6, 128'(16'h400 + i), 1'b1);
        @(negedge clk);
        check("t5_pre_tvalid", 640'(tvalid), 640'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); m_recs.delete(); exp_beats = '0; exp_recs = '0;
        @(negedge clk);
        check("t5_tvalid", 640'(tvalid), 640'(0));
        check("t5_idle", 640'(idle), 640'(1));
        check("t5_overflow", 640'(overflow), 640'(0));
        check_counters("t5");
        @(posedge clk); #1;

        // 6: twelve records to node 5 held back, then released: beats follow without a bubble
        tready = 1'b0;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 3'd5, 128'(16'h500 + i), 1'b1);
        idle_cycles(2);
        tready = 1'b1;
        @(negedge clk);
        check("t6_b2b_first", 640'(tvalid), 640'(1));
        @(negedge clk);
        check("t6_b2b_second", 640'(tvalid), 640'(1));
        @(posedge clk); #1;
        drain("t6");
        check_counters("t6");

        // 7: randomized traffic with random backpressure, source honours almost_full
        for (int i = 0; i < 400; i++) begin
            tready = ($urandom_range(0, 3) != 0);
            if (!almost_full && $urandom_range(0, 9) < 8) begin
                drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                      3'($urandom_range(0, 2)), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
            end else begin
                idle_cycles(1);
            end
        end
        drive(1'b0, 1'b1, 3'd0, '0, 1'b1);
        drain("t7");
        check_counters("t7");
        check("t7_no_overflow", 640'(overflow), 640'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
